// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared state encoding and defaults for spi_mem_controller
// Holds the state typedef (IDLE=0 ... DONE=8, also shown on the LEDs),
// the default command/data phase lengths and the bit-counter width helper.
package spi_mem_pkg;

    localparam int DEF_CMD_BITS  = 8;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        GET_CMD     = 4'd1,
        GOT         = 4'd2,
        READ_WAIT   = 4'd3,
        READ_LOAD   = 4'd4,
        READ_OUT    = 4'd5,
        WRITE_IN    = 4'd6,
        WRITE_STORE = 4'd7,
        DONE        = 4'd8
    } state_t;

    // Wide enough to hold the larger phase length itself.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter with clear, increment and terminal compare
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (wins over inc)
//   inc          : count one SCLK rising edge
//   term         : phase length for the current phase
//   last         : inc is landing on the final edge of the phase
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last = inc && (cnt_q == term - W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != term)) begin
            // Saturate at term so a missed clear can never wrap the count.
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_mem_controller.sv
// rtl/spi_mem_controller.sv - SPI slave memory transaction sequencer
// Optional feature macro: SPI_MEM_FAULT_INJECT_EN (adds input fault).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   cs_cond      : conditioned chip select, 1 = inactive (aborts any transaction)
//   sclk_pos     : one-clk strobe per conditioned SCLK rising edge
//   rw_bit       : shift register bit 0, 1 = read
//   fault        : (macro only) suppresses the memory write strobe
//   addr_we, sr_we, dm_we : address latch / shift load / memory write enables
//   miso_buff    : MISO driver enable, high throughout READ_OUT
//   xfer_done    : one-clk pulse on entry to DONE
//   state_dbg    : current state code
module spi_mem_controller
    import spi_mem_pkg::*;
#(
    parameter int CMD_BITS  = DEF_CMD_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_cond,
    input  logic       sclk_pos,
    input  logic       rw_bit,
`ifdef SPI_MEM_FAULT_INJECT_EN
    input  logic       fault,
`endif
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic       xfer_done,
    output logic [3:0] state_dbg
);

    localparam int CW = cnt_width(CMD_BITS, DATA_BITS);

    state_t  state_q, state_d;
    logic    armed_q, armed_d;
    logic    addr_we_q, addr_we_d;
    logic    sr_we_q, sr_we_d;
    logic    dm_we_q, dm_we_d;
    logic    miso_q, miso_d;
    logic    done_q, done_d;

    logic          fault_w;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic [CW-1:0] cnt_term;

`ifdef SPI_MEM_FAULT_INJECT_EN
    assign fault_w = fault;
`else
    assign fault_w = 1'b0;
`endif

    // Edges are counted only in the shifting states and never once CS drops away.
    assign cnt_inc  = sclk_pos && !cs_cond &&
                      ((state_q == GET_CMD) || (state_q == READ_OUT) || (state_q == WRITE_IN));
    assign cnt_term = (state_q == GET_CMD) ? CW'(CMD_BITS) : CW'(DATA_BITS);

    spi_bit_counter #(.W(CW)) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .term    (cnt_term),
        .last    (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_clr = 1'b0;
        if (cs_cond) begin
            // CS inactive aborts from anywhere and re-arms for the next falling edge.
            state_d = IDLE;
            armed_d = 1'b1;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    // armed_q stays low after reset until CS has been seen inactive.
                    if (armed_q) begin
                        state_d = GET_CMD;
                        armed_d = 1'b0;
                    end
                end
                GET_CMD: begin
                    if (cnt_last) begin
                        state_d = GOT;
                        cnt_clr = 1'b1;
                    end
                end
                GOT:         state_d = rw_bit ? READ_WAIT : WRITE_IN;
                READ_WAIT:   state_d = READ_LOAD;
                READ_LOAD:   state_d = READ_OUT;
                READ_OUT: begin
                    if (cnt_last) begin
                        state_d = DONE;
                        cnt_clr = 1'b1;
                    end
                end
                WRITE_IN: begin
                    if (cnt_last) begin
                        state_d = WRITE_STORE;
                        cnt_clr = 1'b1;
                    end
                end
                WRITE_STORE: state_d = DONE;
                DONE:        state_d = DONE;
                default:     state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        addr_we_d = (state_d == GOT);
        sr_we_d   = (state_d == READ_LOAD);
        dm_we_d   = (state_d == WRITE_STORE) && !fault_w;
        miso_d    = (state_d == READ_OUT);
        done_d    = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            addr_we_q <= 1'b0;
            sr_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            addr_we_q <= addr_we_d;
            sr_we_q   <= sr_we_d;
            dm_we_q   <= dm_we_d;
            miso_q    <= miso_d;
            done_q    <= done_d;
        end
    end

    assign addr_we   = addr_we_q;
    assign sr_we     = sr_we_q;
    assign dm_we     = dm_we_q;
    assign miso_buff = miso_q;
    assign xfer_done = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_mem_controller.sv
// tb/tb_spi_mem_controller.sv - self-checking bench for spi_mem_controller
module tb_spi_mem_controller;

    localparam int N    = 120;
    localparam int RUNS = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs_cond;
    logic       sclk_pos;
    logic       rw_bit;
`ifdef SPI_MEM_FAULT_INJECT_EN
    logic       fault;
`endif
    logic       addr_we, sr_we, dm_we, miso_buff, xfer_done;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_multi  = 0;
    int cnt_addr, cnt_sr, cnt_dm, cnt_miso, cnt_done;

    always #5 clk = ~clk;

    spi_mem_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_cond   (cs_cond),
        .sclk_pos  (sclk_pos),
        .rw_bit    (rw_bit),
`ifdef SPI_MEM_FAULT_INJECT_EN
        .fault     (fault),
`endif
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .xfer_done (xfer_done),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic       cs;
        logic       s;
        logic       rw;
        logic [4:0] eo;   // {addr_we, sr_we, dm_we, miso_buff, xfer_done}
        logic [3:0] es;
    } vec_t;

    vec_t tbl[$];

    logic       cs_a [N];
    logic       s_a  [N];
    logic       rw_a [N];
    logic [4:0] ex   [N];

    function automatic vec_t mk(logic cs, logic s, logic rw, logic [4:0] eo, logic [3:0] es);
        vec_t v;
        v.cs = cs; v.s = s; v.rw = rw; v.eo = eo; v.es = es;
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {addr_we, sr_we, dm_we, miso_buff, xfer_done};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        cnt_addr = 0; cnt_sr = 0; cnt_dm = 0; cnt_miso = 0; cnt_done = 0;
    endtask

    // Drive one clk worth of inputs, then sample just after the edge.
    task automatic cyc(input logic cs, input logic s, input logic rw);
        cs_cond = cs; sclk_pos = s; rw_bit = rw;
        @(posedge clk);
        #1;
        cnt_addr += int'(addr_we);
        cnt_sr   += int'(sr_we);
        cnt_dm   += int'(dm_we);
        cnt_miso += int'(miso_buff);
        cnt_done += int'(xfer_done);
        if (int'(addr_we) + int'(sr_we) + int'(dm_we) > 1) n_multi++;
    endtask

    // Index of the n-th strobe at or after 'from' and before 'lim', or -1.
    function automatic int nth(input int from, input int n, input int lim);
        int seen = 0;
        for (int k = from; k < lim && k < N; k++) begin
            if (s_a[k]) begin
                seen++;
                if (seen == n) return k;
            end
        end
        return -1;
    endfunction

    task automatic put(input int idx, input int bitpos, input int lim);
        if (idx >= 0 && idx < lim && idx < N) ex[idx][bitpos] = 1'b1;
    endtask

    // Transaction-level prediction: CS low starts a command, strobes after
    // the CS-low cycle are counted, enables follow at fixed offsets from the
    // 8th command edge and the 8th data edge; CS high cuts everything off.
    task automatic predict();
        int k, c, ab, g, r, w;
        for (int i = 0; i < N; i++) ex[i] = '0;
        k = 0;
        while (k < N) begin
            if (cs_a[k]) begin
                k++;
                continue;
            end
            c  = k;
            ab = c + 1;
            while (ab < N && !cs_a[ab]) ab++;
            g = nth(c + 1, 8, ab);
            if (g >= 0 && g + 1 < ab) begin
                put(g, 4, ab);
                if (rw_a[g + 1]) begin
                    put(g + 2, 3, ab);
                    r = nth(g + 4, 8, ab);
                    for (int j = g + 3; j < ((r >= 0) ? r : ab); j++) put(j, 1, ab);
                    if (r >= 0) put(r, 0, ab);
                end else begin
                    w = nth(g + 2, 8, ab);
                    if (w >= 0) begin
                        put(w, 2, ab);
                        put(w + 1, 0, ab);
                    end
                end
            end else if (g >= 0) begin
                put(g, 4, ab);
            end
            k = ab;
        end
    endtask

    initial begin
        // Write 0x54 / data 0xC3; CS falls together with an ignored strobe.
        tbl.push_back(mk(1, 0, 0, 5'b00000, 4'd0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 0, 5'b00000, 4'd1));
        tbl.push_back(mk(0, 1, 0, 5'b10000, 4'd2));
        tbl.push_back(mk(0, 0, 0, 5'b00000, 4'd6));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 0, 5'b00000, 4'd6));
        tbl.push_back(mk(0, 1, 0, 5'b00100, 4'd7));
        tbl.push_back(mk(0, 1, 0, 5'b00001, 4'd8));
        tbl.push_back(mk(0, 1, 0, 5'b00000, 4'd8));
        tbl.push_back(mk(1, 0, 0, 5'b00000, 4'd0));
        // Read 0x55 with strobes every cycle; latency-cycle strobes are ignored.
        tbl.push_back(mk(1, 0, 1, 5'b00000, 4'd0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 1, 5'b00000, 4'd1));
        tbl.push_back(mk(0, 1, 1, 5'b10000, 4'd2));
        tbl.push_back(mk(0, 1, 1, 5'b00000, 4'd3));
        tbl.push_back(mk(0, 1, 1, 5'b01000, 4'd4));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 1, 5'b00010, 4'd5));
        tbl.push_back(mk(0, 1, 1, 5'b00001, 4'd8));
        tbl.push_back(mk(0, 0, 1, 5'b00000, 4'd8));
        tbl.push_back(mk(1, 0, 1, 5'b00000, 4'd0));

        reset_n = 1'b0;
`ifdef SPI_MEM_FAULT_INJECT_EN
        fault = 1'b0;
`endif
        cyc(1, 0, 0);
        cyc(0, 1, 1);
        check("reset_outs", {11'd0, outs()}, 16'd0);
        check("reset_state", {12'd0, state_dbg}, 16'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cs, tbl[i].s, tbl[i].rw);
            check($sformatf("vec%0d", i), {7'd0, outs(), state_dbg}, {7'd0, tbl[i].eo, tbl[i].es});
        end

        // Abort after 12 edges of a write.
        cyc(1, 0, 0);
        clr_counts();
        cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        check("abort_pre_state", {12'd0, state_dbg}, 16'd6);
        cyc(1, 0, 0);
        check("abort_state", {12'd0, state_dbg}, 16'd0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0);
        check("abort_no_dm", cnt_dm[15:0], 16'd0);
        check("abort_no_done", cnt_done[15:0], 16'd0);

        // Asynchronous reset in the middle of READ_OUT.
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(0, 1, 1);
        check("rst_pre_miso", {15'd0, miso_buff}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_miso_now", {15'd0, miso_buff}, 16'd0);
        check("rst_state_now", {12'd0, state_dbg}, 16'd0);
        cyc(0, 1, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1);
        check("rst_waits_cs_edge", {12'd0, state_dbg}, 16'd0);
        cyc(1, 0, 1);
        clr_counts();
        cyc(0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1);
        check("rst_next_miso_cycles", cnt_miso[15:0], 16'd8);
        check("rst_next_sr", cnt_sr[15:0], 16'd1);
        check("rst_next_done", cnt_done[15:0], 16'd1);
        check("rst_next_state", {12'd0, state_dbg}, 16'd8);

        // Write with fault held high (no effect without the macro).
        cyc(1, 0, 0);
        clr_counts();
`ifdef SPI_MEM_FAULT_INJECT_EN
        fault = 1'b1;
`endif
        cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
`ifdef SPI_MEM_FAULT_INJECT_EN
        check("fault_dm", cnt_dm[15:0], 16'd0);
        fault = 1'b0;
`else
        check("fault_dm", cnt_dm[15:0], 16'd1);
`endif
        check("fault_done", cnt_done[15:0], 16'd1);
        check("fault_state", {12'd0, state_dbg}, 16'd8);

        // Random traffic against the transaction-level prediction.
        for (int r = 0; r < RUNS; r++) begin
            logic cur;
            cur = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (cur) cur = ($urandom_range(0, 2) == 0);
                else     cur = ($urandom_range(0, 49) == 0);
                cs_a[k] = cur;
                s_a[k]  = 1'($urandom_range(0, 1));
                rw_a[k] = 1'($urandom_range(0, 1));
            end
            predict();
            cyc(1, 0, 0);
            for (int k = 0; k < N; k++) begin
                cyc(cs_a[k], s_a[k], rw_a[k]);
                check($sformatf("rand_r%0d_c%0d", r, k), {11'd0, outs()}, {11'd0, ex[k]});
            end
        end

        check("one_hot_we", n_multi[15:0], 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_controller.md
SPI_MEM_CONTROLLER -- requirements
Module: spi_mem_controller

Interface
REQ-001 SHALL have parameter CMD_BITS, default 8, meaning command length in SCLK rising edges (7 address bits MSB-first, then R/W bit).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data phase length in SCLK rising edges.
REQ-003 SHALL have port clk, input, 1, the single FPGA clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port cs_cond, input, 1, conditioned chip select; 1 means inactive.
REQ-006 SHALL have port sclk_pos, input, 1, one-clk strobe marking a conditioned SCLK rising edge.
REQ-007 SHALL have port rw_bit, input, 1, shift register parallel-out bit 0; 1 means read.
REQ-008 SHALL have port addr_we, output, 1, address latch write enable.
REQ-009 SHALL have port sr_we, output, 1, shift register parallel-load enable.
REQ-010 SHALL have port dm_we, output, 1, data memory write enable.
REQ-011 SHALL have port miso_buff, output, 1, MISO tri-state enable.
REQ-012 SHALL have port xfer_done, output, 1, one-clk pulse on entry to DONE.
REQ-013 SHALL have port state_dbg, output, 4, current state code, for the LEDs.

Function
REQ-014 SHALL implement states IDLE, GET_CMD, GOT, READ_WAIT, READ_LOAD, READ_OUT, WRITE_IN, WRITE_STORE, DONE; all outputs are registered Moore outputs.
REQ-015 SHALL move IDLE->GET_CMD when cs_cond=0 and clear the bit counter; an sclk_pos in that same cycle is ignored.
REQ-016 SHALL increment the bit counter on each sclk_pos in GET_CMD, READ_OUT and WRITE_IN, then move to the next state and clear the counter in the cycle the count reaches CMD_BITS or DATA_BITS.
REQ-017 SHALL hold GOT for exactly one clk with addr_we=1, then go to READ_WAIT if rw_bit=1, else WRITE_IN.
REQ-018 SHALL hold READ_WAIT for one clk (memory latency) with all enables 0.
REQ-019 SHALL hold READ_LOAD for one clk with sr_we=1.
REQ-020 SHALL assert miso_buff=1 for all of READ_OUT and only in READ_OUT; READ_OUT ends after DATA_BITS sclk_pos strobes.
REQ-021 SHALL hold WRITE_STORE for one clk with dm_we=1.
REQ-022 SHALL stay in DONE, outputs 0, until cs_cond=1; extra sclk_pos strobes in DONE are ignored.
REQ-023 SHALL go to IDLE on the next clk whenever cs_cond=1 in any state (abort); cs_cond=1 takes priority over every other transition, and an aborted write produces no dm_we.
REQ-024 SHALL assert at most one of addr_we, sr_we, dm_we in any cycle.
REQ-025 SHALL use a counter width of $clog2(max(CMD_BITS,DATA_BITS)+1); the counter never wraps.

Reset
REQ-026 SHALL, while reset_n=0, force the state to IDLE, the counter to 0, all enables, miso_buff and xfer_done to 0, and state_dbg to the IDLE code 0.
REQ-027 SHALL, when reset is asserted mid-transaction, discard that transaction; after release it waits in IDLE for a fresh cs_cond falling edge.

Configuration
REQ-028 SHALL, with SPI_MEM_FAULT_INJECT_EN defined, add input port fault (1 bit); fault=1 during WRITE_STORE suppresses dm_we while the state sequence is unchanged.
REQ-029 SHALL, without SPI_MEM_FAULT_INJECT_EN, have no fault port and behave as if fault=0.

Structure
REQ-030 SHALL take the state encoding (IDLE=0 ... DONE=8), the default CMD_BITS and DATA_BITS, and the state typedef from shared package spi_mem_pkg.
REQ-031 SHALL place the bit counter in sub-module spi_bit_counter, which has clear, increment and terminal-count-compare logic.

Verification
REQ-032 SHALL cover the write case: cs low, command 0x54 (address 0x2A, W), data 0xC3 -> addr_we 1 clk after the 8th edge, dm_we 1 clk after the 16th edge, xfer_done 1 clk after that.
REQ-033 SHALL cover the read case: command 0x55 (address 0x2A, R) -> addr_we, one idle clk, sr_we 1 clk, then miso_buff=1 for exactly 8 sclk_pos strobes, then DONE.
REQ-034 SHALL cover abort: cs_cond=1 after 12 edges of a write -> IDLE next clk, dm_we never asserted.
REQ-035 SHALL cover async reset asserted in READ_OUT -> miso_buff=0 immediately; the next transaction completes normally.
REQ-036 SHALL cover fault: with the macro defined, fault=1 during a write -> dm_we stays 0 and xfer_done still pulses.
REQ-037 SHALL cover cs_cond falling in the same clk as sclk_pos -> that edge is not counted; the command needs 8 further edges.
